// File: rtl/addsub_pkg.sv
// ============================================================================
// addsub_pkg : shared width, state encoding and round-robin helper
// Rev 1.0
// ============================================================================
`default_nettype none

package addsub_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_arbiter_if.sv
// ============================================================================
// addsub_arbiter_if : requester-side and consumer-side handshake bundle
// Optional rsp_ovf present when ADDSUB_ARB_OVF_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

interface addsub_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import addsub_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [DATA_W*NREQ-1:0] req_x;
  logic [DATA_W*NREQ-1:0] req_y;
  logic [NREQ-1:0]        req_sub;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [DATA_W-1:0]      rsp_s;
  logic                   rsp_cout;
`ifdef ADDSUB_ARB_OVF_EN
  logic                   rsp_ovf;
`endif

  modport master (
    output req_valid, req_x, req_y, req_sub, rsp_ready,
`ifdef ADDSUB_ARB_OVF_EN
    input  rsp_ovf,
`endif
    input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout
  );

  modport slave (
    input  req_valid, req_x, req_y, req_sub, rsp_ready,
`ifdef ADDSUB_ARB_OVF_EN
    output rsp_ovf,
`endif
    output req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout
  );

endinterface

`default_nettype wire

// File: rtl/ADDSUB_32.sv
// ============================================================================
// ADDSUB_32 : 32-bit adder/subtractor, S = X + (Y ^ {32{Sub}}) + Sub
// Rev 1.0
// ============================================================================
`default_nettype none

module ADDSUB_32 (
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        Sub,
  output logic [31:0] S,
  output logic        Cout
);

  assign {Cout, S} = {1'b0, X} + {1'b0, Y ^ {32{Sub}}} + {32'd0, Sub};

endmodule

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// rr_picker : first valid requester at or after ptr, wrapping NREQ-1 -> 0
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx,
  output logic            any
);

  localparam int c_iw = IDW + 1;

  logic [IDW:0] w_idx;

  // ptr + k never exceeds 2*NREQ-2, so one conditional subtract wraps it
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, ptr} + c_iw'(k);
      if (w_idx >= c_iw'(NREQ)) begin
        w_idx = w_idx - c_iw'(NREQ);
      end
      if (!any && valid[w_idx[IDW-1:0]]) begin
        any                  = 1'b1;
        gidx                 = w_idx[IDW-1:0];
        grant[w_idx[IDW-1:0]] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/addsub_arbiter.sv
// ============================================================================
// addsub_arbiter : round-robin share of one ADDSUB_32 across NREQ requesters
// Optional signed-overflow output under ADDSUB_ARB_OVF_EN. Rev 1.0
// ============================================================================
`default_nettype none

module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  addsub_arbiter_if.slave  bus
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_HOLD = HOLD;

  logic [0:0]        r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [DATA_W-1:0] r_s;
  logic              r_cout;

  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_gidx;
  logic              w_any;
  logic              w_accept;
  logic [DATA_W-1:0] w_xa [NREQ];
  logic [DATA_W-1:0] w_ya [NREQ];
  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_y;
  logic              w_sub;
  logic [DATA_W-1:0] w_s;
  logic              w_cout;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_xa[i] = bus.req_x[DATA_W*i +: DATA_W];
    assign w_ya[i] = bus.req_y[DATA_W*i +: DATA_W];
  end

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .valid (bus.req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .gidx  (w_gidx),
    .any   (w_any)
  );

  // A held result blocks new grants until the consumer takes it
  assign w_accept      = w_any && ((r_state == S_IDLE) || bus.rsp_ready);
  assign bus.req_ready = w_accept ? w_grant : '0;

  assign w_x   = w_xa[w_gidx];
  assign w_y   = w_ya[w_gidx];
  assign w_sub = bus.req_sub[w_gidx];

  ADDSUB_32 u_addsub (
    .X    (w_x),
    .Y    (w_y),
    .Sub  (w_sub),
    .S    (w_s),
    .Cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_HOLD;
      r_ptr   <= IDW'(rr_next(32'(w_gidx), NREQ));
      r_id    <= w_gidx;
      r_s     <= w_s;
      r_cout  <= w_cout;
    end else if ((r_state == S_HOLD) && bus.rsp_ready) begin
      r_state <= S_IDLE;
    end
  end

  assign bus.rsp_valid = (r_state == S_HOLD);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_s     = r_s;
  assign bus.rsp_cout  = r_cout;

`ifdef ADDSUB_ARB_OVF_EN
  logic              r_ovf;
  logic [DATA_W-1:0] w_yeff;
  logic              w_ovf;

  assign w_yeff = w_y ^ {DATA_W{w_sub}};
  assign w_ovf  = (w_x[DATA_W-1] == w_yeff[DATA_W-1]) && (w_s[DATA_W-1] != w_x[DATA_W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= w_ovf;
    end
  end

  assign bus.rsp_ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 32-bit adder/subtractor datapath (operands X, Y, Sub; results S, Cout) between NREQ independent requesters.
- Round-robin arbitration with a valid/ready handshake on both sides; the result is registered and returned tagged with the requester index.
- Sits between the per-unit issue logic and the single ADDSUB_32 instance. Throughput is 1 op/cycle when the consumer is always ready.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index; must equal clog2(NREQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_x  in  32*NREQ  flattened X operands; requester i occupies [32i+31:32i].
- req_y  in  32*NREQ  flattened Y operands, same packing as req_x.
- req_sub  in  NREQ  per-requester op select: 1 = X-Y, 0 = X+Y.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_s  out  32  result.
- rsp_cout  out  1  adder carry-out.

Behaviour:
- Reset values, async on rst high: rsp_valid=0, rsp_s=0, rsp_cout=0, rsp_id=0, rr pointer=0, state IDLE. req_ready is combinational and therefore 0 while the state is IDLE with no valid requests.
- Arithmetic:
  - S = X + (Y ^ {32{Sub}}) + Sub, modulo 2^32.
  - Cout is the carry out of bit 31. For Sub=1, Cout=1 means no borrow (X >= Y unsigned).
- State IDLE:
  - If any req_valid is high, grant g = first valid index at or after the pointer, searching upward and wrapping NREQ-1 -> 0.
  - req_ready[g]=1 in the same cycle. The adder sees the operands of g; S, Cout and g are registered at the clock edge.
  - Next cycle: rsp_valid=1 and the state moves to HOLD. Latency is 1 cycle from accept to rsp_valid.
  - Pointer becomes (g+1) mod NREQ on every accept.
- State HOLD:
  - rsp_* stay stable while rsp_ready=0, and req_ready is all-zero.
  - If rsp_ready=1 and a request is pending, the result is consumed and the new request is accepted in the same cycle (back-to-back). rsp_valid stays 1 with new data next cycle.
  - If rsp_ready=1 and no request is pending, go to IDLE and rsp_valid=0 next cycle.
- Requester rule: req_x, req_y and req_sub must be held stable while req_valid=1 and req_ready=0. Deasserting valid before ready is allowed; the request is then simply withdrawn.
- Simultaneous requests from all NREQ requesters: each is served exactly once in NREQ consecutive accepts (fairness). No requester waits more than NREQ-1 grants.
- Pointer wrap: after granting NREQ-1 the pointer becomes 0.
- Reset mid-operation: an in-flight or held result is discarded, and no response is ever issued for it.
- rsp_s and rsp_cout are don't-care while rsp_valid=0, but are held at their last value.

Optional Feature:
- ADDSUB_ARB_OVF_EN: when defined, adds output port rsp_ovf (1 bit), registered with the result.
  - rsp_ovf = signed overflow = (X[31] == Yeff[31]) && (S[31] != X[31]), where Yeff = Y ^ {32{Sub}}.
  - Reset value 0.
- When not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package addsub_pkg holds:
  - DATA_W=32.
  - The state encoding, a typedef enum {IDLE, HOLD}.
  - Function rr_next(ptr, n), returning (ptr+1) mod n.
- One natural sub-module: rr_picker (combinational inputs valid[NREQ] and ptr; outputs grant one-hot, grant index and any).
- The datapath is an instance of the existing ADDSUB_32.

Test Plan:
- Single op: rst pulse; req_valid=0001, x0=136, y0=17, sub0=1, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_s=119, rsp_cout=1.
- Borrow and wrap: requester 2, x=17, y=136, sub=1 -> rsp_s=32'hFFFFFF89, rsp_cout=0. Then x=FFFFFFFF, y=FFFFFFFE, sub=0 -> rsp_s=FFFFFFFD, rsp_cout=1.
- Fairness: all four req_valid high continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles, with rsp_valid high every cycle.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending -> rsp_* frozen and req_ready=0000. Raising rsp_ready -> the next grant is issued in that same cycle.
- Reset mid-HOLD: assert rst while rsp_valid=1 -> rsp_valid=0 immediately (async), and after release the first grant goes to requester 0.
- With ADDSUB_ARB_OVF_EN: x=7FFFFFFF, y=1, sub=0 -> rsp_ovf=1, rsp_s=80000000. Then x=80000000, y=1, sub=1 -> rsp_ovf=1.
